// File: rtl/dvi_clk_sequencer.sv
// dvi_clk_sequencer
//   Brings up the DVI pixel domain from the PLL bit clock. Waits for the PLL
//   lock indicator to be stable for LOCK_STABLE_CYCLES cycles, then releases
//   a downstream reset and generates a pixel clock-enable plus serializer
//   phase (divide by DIV). A lock loss while running drops everything back
//   into reset and sets a sticky lock_lost flag.
// Ports
//   clk        bit clock (PLL output), sole clock domain
//   rst_n      synchronous active-low reset
//   pll_locked PLL lock, asynchronous, synchronised here
//   rst_n_out  registered active-low reset for downstream DVI logic
//   pix_en     one-cycle strobe every DIV cycles, coincident with phase==0
//   phase      serializer phase 0..DIV-1
//   lock_lost  sticky: lock was lost while running (cleared by rst_n only)
module dvi_clk_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DIV                = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       rst_n_out,
  output logic       pix_en,
  output logic [2:0] phase,
  output logic       lock_lost
);

  localparam int             CW      = $clog2(LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]     PH_MAX  = 3'(DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sync1, locked_s;
  logic [2:0]    phase_n;

  // Two-flop synchroniser for the asynchronous lock indicator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABILISE;
          cnt_n   = '0;
        end
      end
      STABILISE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          // cnt holds at its terminal value; it never wraps
          state_n = RUN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) state_n = WAIT_LOCK;
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
  end

  assign phase_n = (phase == PH_MAX) ? 3'd0 : phase + 3'd1;

  // Outputs are registered off the next state so they change on the same
  // edge as the state transition (entry to RUN releases reset at once).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rst_n_out <= 1'b0;
      pix_en    <= 1'b0;
      phase     <= 3'd0;
      lock_lost <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state_n == RUN) begin
        rst_n_out <= 1'b1;
        if (state != RUN) begin
          phase  <= 3'd0;
          pix_en <= 1'b1;
        end else begin
          phase  <= phase_n;
          pix_en <= (phase_n == 3'd0);
        end
      end else begin
        rst_n_out <= 1'b0;
        pix_en    <= 1'b0;
        phase     <= 3'd0;
        if (state == RUN) lock_lost <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dvi_clk_sequencer.md
DVI_CLK_SEQUENCER -- requirements
Module: dvi_clk_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024, number of consecutive synchronised-lock cycles required before reset release; legal range 2..65536.
REQ-002 Parameter DIV, default 5, bit-clock to pixel-clock ratio; legal range 2..8.
REQ-003 clk  input  1  bit clock from PLL output (126 MHz nominal); single clock domain for all logic.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 pll_locked  input  1  PLL lock indicator; asynchronous to clk; SHALL be synchronised internally.
REQ-006 rst_n_out  output  1  registered synchronous active-low reset for downstream DVI logic.
REQ-007 pix_en  output  1  registered one-cycle pixel clock-enable strobe.
REQ-008 phase  output  3  registered serializer phase, 0..DIV-1.
REQ-009 lock_lost  output  1  registered sticky flag: lock lost while running.

Function
REQ-010 pll_locked SHALL pass through a 2-flop synchroniser; locked_s denotes the second flop output.
REQ-011 The FSM SHALL have exactly three states: WAIT_LOCK, STABILISE, RUN.
REQ-012 WAIT_LOCK: if locked_s=1 at an edge -> STABILISE with stable counter cnt<=0; else remain.
REQ-013 STABILISE: if locked_s=0 -> WAIT_LOCK, cnt<=0; else if cnt==LOCK_STABLE_CYCLES-1 -> RUN; else cnt<=cnt+1.
REQ-014 RUN: if locked_s=0 -> WAIT_LOCK; else remain.
REQ-015 cnt width SHALL be $clog2(LOCK_STABLE_CYCLES); cnt SHALL never wrap.
REQ-016 Outside RUN: rst_n_out=0, pix_en=0, phase=0.
REQ-017 On the edge entering RUN: rst_n_out<=1, phase<=0, pix_en<=1.
REQ-018 Each further edge in RUN: phase<=(phase==DIV-1)?0:phase+1; pix_en<=1 iff the new phase is 0.
REQ-019 pix_en SHALL therefore pulse for exactly one cycle in every DIV cycles, coincident with phase==0.
REQ-020 On the edge leaving RUN (lock loss): rst_n_out<=0, pix_en<=0, phase<=0, lock_lost<=1, all on that same edge.
REQ-021 lock_lost SHALL be cleared only by rst_n; further lock losses leave it at 1.
REQ-022 Latency: rst_n_out SHALL rise exactly LOCK_STABLE_CYCLES+3 edges after the first edge sampling pll_locked=1, counting that edge as 1, provided lock holds throughout.
REQ-023 Latency: rst_n_out SHALL fall on the 3rd edge after the first edge sampling pll_locked=0 while in RUN.
REQ-024 A pll_locked low pulse during STABILISE that reaches locked_s SHALL restart the full stabilisation count.
REQ-025 A pll_locked glitch too short to be captured by the first synchroniser flop has no required effect.

Reset
REQ-026 rst_n=0 at an edge SHALL force: state=WAIT_LOCK, synchroniser flops=0, cnt=0, rst_n_out=0, pix_en=0, phase=0, lock_lost=0.
REQ-027 Reset SHALL take priority over all state transitions, including mid-RUN and mid-STABILISE.
REQ-028 After rst_n returns to 1 with pll_locked already high, the full REQ-022 sequence SHALL apply from the first non-reset edge.

Verification (LOCK_STABLE_CYCLES=8, DIV=5 unless noted)
REQ-029 Power-up: rst_n low for 4 cycles, then high; pll_locked rises before edge 1 and stays high -> rst_n_out rises after edge 11. pix_en=1 on edges 11, 16, 21. phase sequence 0,1,2,3,4,0.
REQ-030 Lock loss in RUN: pll_locked falls before edge k -> rst_n_out, pix_en and phase equal 0 after edge k+2. lock_lost=1 after edge k+2 and stays 1 through the later re-lock, which repeats the 11-edge release.
REQ-031 Lock drop in STABILISE: pll_locked low for 2 cycles with cnt=5 -> return to WAIT_LOCK. rst_n_out stays 0. The next rise needs the full 11 edges.
REQ-032 Reset mid-RUN: rst_n=0 for 1 cycle at phase=3 -> all outputs 0 after that edge, including lock_lost. Release restarts at 11 edges.
REQ-033 DIV=2 and DIV=8 sweeps: pix_en period equals DIV. phase never exceeds DIV-1. Exactly one pix_en per period over 100 periods.
REQ-034 Stress: random pll_locked toggling over 10^5 cycles -> assertions hold: rst_n_out=0 implies pix_en=0 and phase=0; pix_en=1 iff (rst_n_out=1 and phase=0).
